// File: rtl/btb_update_scheduler_pkg.sv
// Shared types for the BTB update scheduler:
// update record carried through the pending FIFO and scheduler states.
package btb_update_scheduler_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
  } btb_update_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/btb_update_scheduler.sv
// Shares the single BTB port between fetch lookups and queued
// branch updates; also sweeps the table clean on flush.
module btb_update_scheduler
  import btb_update_scheduler_pkg::*;
#(
  parameter int BTB_SIZE     = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_lookup_req,
  input  logic                        i_res_valid,
  input  logic [ADDR_WIDTH-1:0]       i_res_pc,
  input  logic [ADDR_WIDTH-1:0]       i_res_target,
  input  logic                        i_res_taken,
  input  logic                        i_flush_req,
  output logic                        o_res_ready,
  output logic                        o_lookup_grant,
  output logic                        o_lookup_stall,
  output logic                        o_btb_we,
  output logic [$clog2(BTB_SIZE)-1:0] o_btb_idx,
  output logic [ADDR_WIDTH-1:0]       o_btb_wr_pc,
  output logic [ADDR_WIDTH-1:0]       o_btb_wr_target,
  output logic                        o_btb_wr_valid,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int IW = $clog2(BTB_SIZE);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int UW = $bits(btb_update_t);
  localparam logic [IW-1:0] LAST_IDX = IW'(BTB_SIZE - 1);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

  sched_state_e state, state_nxt;
  logic [IW-1:0] sweep, sweep_nxt;
  logic [SW-1:0] starve, starve_nxt;

  btb_update_t   res_in;
  btb_update_t   head;
  logic [UW-1:0] head_bits;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_clear;
  logic          fifo_pop;
  logic          fifo_push;

  assign res_in    = '{pc: i_res_pc, target: i_res_target,
                       taken: i_res_taken};
  assign head      = head_bits;
  assign fifo_push = i_res_valid && o_res_ready;

  sync_fifo #(
    .WIDTH (UW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (res_in),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sweep  <= '0;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      sweep  <= sweep_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    sweep_nxt       = sweep;
    starve_nxt      = starve;
    fifo_clear      = 1'b0;
    fifo_pop        = 1'b0;
    o_lookup_grant  = 1'b0;
    o_btb_we        = 1'b0;
    o_btb_idx       = '0;
    o_btb_wr_pc     = '0;
    o_btb_wr_target = '0;
    o_btb_wr_valid  = 1'b0;
    o_busy          = 1'b0;
    o_res_ready     = !fifo_full && (state == IDLE) && !i_flush_req;
    unique case (state)
      IDLE: begin
        if (i_flush_req) begin
          // pending updates are stale once the table is wiped
          state_nxt      = FLUSH;
          fifo_clear     = 1'b1;
          sweep_nxt      = '0;
          starve_nxt     = '0;
          o_lookup_grant = i_lookup_req;
        end else if (i_lookup_req && (starve < LIMIT)) begin
          o_lookup_grant = 1'b1;
          if (!fifo_empty) starve_nxt = starve + 1'b1;
        end else if (!fifo_empty) begin
          o_btb_we        = 1'b1;
          o_btb_idx       = head.pc[IW+1:2];
          o_btb_wr_pc     = head.pc;
          o_btb_wr_target = head.target;
          o_btb_wr_valid  = head.taken;
          fifo_pop        = 1'b1;
          starve_nxt      = '0;
        end else begin
          o_lookup_grant = i_lookup_req;
          starve_nxt     = '0;
        end
      end
      FLUSH: begin
        o_busy    = 1'b1;
        o_btb_we  = 1'b1;
        o_btb_idx = sweep;
        if (i_flush_req) begin
          sweep_nxt = '0;
        end else if (sweep == LAST_IDX) begin
          state_nxt = IDLE;
          sweep_nxt = '0;
        end else begin
          sweep_nxt = sweep + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_lookup_stall = i_lookup_req && !o_lookup_grant;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Scoreboard bench for btb_update_scheduler against a
// queue-based reference model of the scheduling rules.
module tb_btb_update_scheduler;
  import btb_update_scheduler_pkg::*;

  localparam int BTB_SIZE     = 16;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_req = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic [31:0] res_target = '0;
  logic        res_taken = 1'b0;
  logic        flush_req = 1'b0;
  logic        res_ready;
  logic        lookup_grant;
  logic        lookup_stall;
  logic        btb_we;
  logic [3:0]  btb_idx;
  logic [31:0] btb_wr_pc;
  logic [31:0] btb_wr_target;
  logic        btb_wr_valid;
  logic        busy;
  logic [2:0]  count;

  always #5 clk = ~clk;

  btb_update_scheduler #(
    .BTB_SIZE     (BTB_SIZE),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_lookup_req    (lookup_req),
    .i_res_valid     (res_valid),
    .i_res_pc        (res_pc),
    .i_res_target    (res_target),
    .i_res_taken     (res_taken),
    .i_flush_req     (flush_req),
    .o_res_ready     (res_ready),
    .o_lookup_grant  (lookup_grant),
    .o_lookup_stall  (lookup_stall),
    .o_btb_we        (btb_we),
    .o_btb_idx       (btb_idx),
    .o_btb_wr_pc     (btb_wr_pc),
    .o_btb_wr_target (btb_wr_target),
    .o_btb_wr_valid  (btb_wr_valid),
    .o_busy          (busy),
    .o_count         (count)
  );

  typedef struct {
    bit ready, grant, stall, we, busy;
    int count;
  } ctl_t;

  typedef struct {
    int idx;
    bit [31:0] pc, target;
    bit valid;
  } wr_t;

  typedef struct {
    bit [31:0] pc, target;
    bit taken;
  } upd_t;

  ctl_t cq[$];
  wr_t  wq[$];

  // reference model state
  upd_t m_q[$];
  int   m_starve;
  bit   m_busy;
  int   m_sweep;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_busy   = 0;
    m_sweep  = 0;
  endtask

  task automatic cyc(bit lk, bit rv, bit [31:0] pc,
                     bit [31:0] tg, bit tk, bit fl, bit rs);
    ctl_t c;
    wr_t  w;
    bit   full;
    @(posedge clk);
    #1;
    lookup_req = lk;
    res_valid  = rv;
    res_pc     = pc;
    res_target = tg;
    res_taken  = tk;
    flush_req  = fl;
    rst        = rs;
    full    = (m_q.size() == FIFO_DEPTH);
    c       = '{default: 0};
    w       = '{default: 0};
    c.ready = !m_busy && !full && !fl;
    c.busy  = m_busy;
    c.count = m_q.size();
    if (m_busy) begin
      c.we  = 1;
      w.idx = m_sweep;
    end else if (fl) begin
      c.grant = lk;
    end else if (lk && m_starve < STARVE_LIMIT) begin
      c.grant = 1;
    end else if (m_q.size() > 0) begin
      c.we    = 1;
      w.idx   = (m_q[0].pc / 4) % BTB_SIZE;
      w.pc    = m_q[0].pc;
      w.target = m_q[0].target;
      w.valid = m_q[0].taken;
    end else begin
      c.grant = lk;
    end
    c.stall = lk && !c.grant;
    cq.push_back(c);
    if (c.we) wq.push_back(w);
    if (rs) begin
      model_reset();
    end else if (m_busy) begin
      if (fl) m_sweep = 0;
      else if (m_sweep == BTB_SIZE - 1) begin
        m_busy  = 0;
        m_sweep = 0;
      end else m_sweep++;
    end else if (fl) begin
      m_q.delete();
      m_busy   = 1;
      m_sweep  = 0;
      m_starve = 0;
    end else begin
      if (c.we) begin
        void'(m_q.pop_front());
        m_starve = 0;
      end else if (c.grant && m_q.size() > 0) m_starve++;
      if (rv && c.ready) m_q.push_back('{pc, tg, tk});
      if (m_q.size() == 0) m_starve = 0;
    end
  endtask

  task automatic idle(int n, bit lk);
    for (int i = 0; i < n; i++) cyc(lk, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    ctl_t c;
    wr_t  w;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk("res_ready", res_ready, c.ready);
      chk("lookup_grant", lookup_grant, c.grant);
      chk("lookup_stall", lookup_stall, c.stall);
      chk("btb_we", btb_we, c.we);
      chk("busy", busy, c.busy);
      chk("count", count, c.count);
      if (btb_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          w = wq.pop_front();
          chk("wr_idx", btb_idx, w.idx);
          chk("wr_pc", btb_wr_pc, w.pc);
          chk("wr_target", btb_wr_target, w.target);
          chk("wr_valid", btb_wr_valid, w.valid);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);
    // single taken update, no lookups
    cyc(0, 1, 32'h40, 32'h100, 1, 0, 0);
    idle(3, 0);
    // starvation guard with lookup held
    cyc(1, 1, 32'h80, 32'h200, 1, 0, 0);
    idle(12, 1);
    // overfill with lookup held, then drain
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 32'h100 + 4 * i, 32'h1000 + i, 1, 0, 0);
    idle(6, 0);
    // not-taken invalidates its slot
    cyc(0, 1, 32'h44, 32'h300, 0, 0, 0);
    idle(3, 0);
    // flush with three queued updates
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 32'h200 + 4 * i, 32'h2000 + i, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    idle(20, 1);
    // reset mid-sweep at index 7
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(7, 1);
    cyc(1, 1, 32'h40, 32'h50, 1, 0, 1);
    idle(3, 1);
    // flush restart mid-sweep
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(5, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(20, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          $urandom, $urandom, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) == 0,
          $urandom_range(0, 499) == 0);
    end
    idle(2, 0);
    @(negedge clk);
    #1;
    chk("wq_drained", wq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
